// File: rtl/m92_int_gen.sv
// M92 interrupt source generator: video, sprite-DMA and sound events
// turned into stretched edge requests for the PIC.
module m92_int_gen #(
    parameter int unsigned HOLD         = 4,
    parameter bit          VBL_EN_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       cs,
    input  logic       wr,
    input  logic       a1,
    input  logic [7:0] din,
    input  logic [8:0] vcount,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       dma_done,
    input  logic       snd_irq,
    output logic [7:0] intp
);

    localparam logic [2:0] HOLD_V = 3'(HOLD);

    logic       [8:0] rl;
    logic             rast_en;
    logic             vbl_en;
    logic             hblank_q;
    logic             vblank_q;
    logic             snd_s1;
    logic             snd_s2;
    logic [2:0][2:0] cnt;
    logic [2:0][2:0] cnt_nx;
    logic       [2:0] trig;
    logic       [3:0] req;
    logic             reg_wr;

    assign reg_wr = cs & wr & ce;
    assign intp   = {4'b0000, req};

    // Compare always sees the registers as they were before this cycle's write
    always_comb begin
        trig    = '0;
        trig[0] = vblank & ~vblank_q & vbl_en;
        trig[1] = dma_done;
        trig[2] = hblank & ~hblank_q & rast_en & (vcount == rl);
        cnt_nx  = cnt;
        for (int i = 0; i < 3; i++) begin
            if (trig[i])
                cnt_nx[i] = HOLD_V;
            else if (cnt[i] != 3'd0)
                cnt_nx[i] = cnt[i] - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rl       <= '0;
            rast_en  <= 1'b0;
            vbl_en   <= VBL_EN_RESET;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            cnt      <= '0;
            req      <= '0;
        end else if (ce) begin
            hblank_q <= hblank;
            vblank_q <= vblank;
            cnt      <= cnt_nx;
            for (int i = 0; i < 3; i++)
                req[i] <= (cnt_nx[i] != 3'd0);
            req[3]   <= snd_s2;
            if (reg_wr) begin
                if (!a1) begin
                    rl[7:0] <= din;
                end else begin
                    rl[8]   <= din[0];
                    rast_en <= din[7];
                    vbl_en  <= din[6];
                end
            end
        end
    end

    // Sound request is asynchronous; synchronize on every clk, not just ce
    always_ff @(posedge clk) begin
        if (reset) begin
            snd_s1 <= 1'b0;
            snd_s2 <= 1'b0;
        end else begin
            snd_s1 <= snd_irq;
            snd_s2 <= snd_s1;
        end
    end

endmodule

// File: tb/tb_m92_int_gen.sv
// Bench for m92_int_gen: directed scenarios plus random traffic, all
// checked every clock against an event-age reference model.
module tb_m92_int_gen;

    localparam int HOLD         = 4;
    localparam bit VBL_EN_RESET = 1'b1;

    logic       clk = 1'b0;
    logic       reset, ce, cs, wr, a1;
    logic [7:0] din;
    logic [8:0] vcount;
    logic       hblank, vblank, dma_done, snd_irq;
    logic [7:0] intp;

    int n_cmp = 0;
    int n_bad = 0;

    m92_int_gen #(.HOLD(HOLD), .VBL_EN_RESET(VBL_EN_RESET)) dut (
        .clk(clk), .reset(reset), .ce(ce), .cs(cs), .wr(wr),
        .a1(a1), .din(din), .vcount(vcount), .hblank(hblank),
        .vblank(vblank), .dma_done(dma_done), .snd_irq(snd_irq),
        .intp(intp)
    );

    always #5 clk = ~clk;

    // Reference: each source remembers how many ce cycles ago it last fired
    logic [8:0] m_rl;
    logic       m_rast, m_vbl, m_hb, m_vb, m_snd;
    int         age [3];
    logic       hist [2];
    logic [2:0] t;
    logic [7:0] exp_intp = 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            m_rl = 0; m_rast = 0; m_vbl = VBL_EN_RESET;
            m_hb = 0; m_vb = 0; m_snd = 0;
            for (int i = 0; i < 3; i++) age[i] = HOLD;
            hist[0] = 0; hist[1] = 0;
        end else begin
            if (ce) begin
                t[0] = vblank && !m_vb && m_vbl;
                t[1] = dma_done;
                t[2] = hblank && !m_hb && m_rast && (vcount == m_rl);
                for (int i = 0; i < 3; i++)
                    if (t[i]) age[i] = 0;
                    else if (age[i] < HOLD) age[i] = age[i] + 1;
                m_snd = hist[1];
                if (cs && wr) begin
                    if (!a1) m_rl[7:0] = din;
                    else begin
                        m_rl[8] = din[0]; m_rast = din[7]; m_vbl = din[6];
                    end
                end
                m_hb = hblank; m_vb = vblank;
            end
            hist[1] = hist[0];
            hist[0] = snd_irq;
        end
        exp_intp = {4'b0, m_snd, age[2] < HOLD, age[1] < HOLD, age[0] < HOLD};
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %02h want %02h", tag, $time, got, want);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        chk(tag, intp, exp_intp);
    endtask

    task automatic wr_reg(input logic addr, input logic [7:0] d);
        cs = 1; wr = 1; a1 = addr; din = d;
        step("write");
        cs = 0; wr = 0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        reset = 1; ce = 1; cs = 0; wr = 0; a1 = 0; din = 0;
        vcount = 0; hblank = 0; vblank = 0; dma_done = 0; snd_irq = 0;

        // Reset held with everything toggling
        for (int i = 0; i < 3; i++) begin
            {cs, wr, a1, hblank, vblank, dma_done, snd_irq} = 7'($urandom);
            din = 8'($urandom); vcount = 9'($urandom);
            step("reset");
            chk("reset_zero", intp, 8'h00);
        end
        reset = 0; cs = 0; wr = 0; hblank = 0; vblank = 0;
        dma_done = 0; snd_irq = 0; vcount = 0;
        step("post_reset");
        chk("post_reset_zero", intp, 8'h00);

        // Vblank with reset enable, then disabled
        vblank = 1; step("vbl_rise");
        chk("vbl_bit", intp & 8'h01, 8'h01);
        idle(5, "vbl_hold"); vblank = 0; idle(2, "vbl_low");
        wr_reg(1, 8'h00);
        vblank = 1; step("vbl_off");
        chk("vbl_off_bit", intp & 8'h01, 8'h00);
        idle(3, "vbl_off"); vblank = 0;

        // Raster at line 0x140, then non-matching line 0x040
        wr_reg(0, 8'h40); wr_reg(1, 8'h81);
        vcount = 9'h140; step("ras_pre");
        hblank = 1; step("ras_edge");
        chk("ras_bit", intp & 8'h04, 8'h04);
        idle(5, "ras_hold"); hblank = 0; step("ras_low");
        vcount = 9'h040; hblank = 1; idle(3, "ras_miss"); hblank = 0;

        // DMA retrigger at ce cycles 0 and 2
        dma_done = 1; step("dma0"); dma_done = 0; step("dma1");
        dma_done = 1; step("dma2"); dma_done = 0;
        idle(3, "dma_hold");
        chk("dma_still", intp & 8'h02, 8'h02);
        idle(2, "dma_end");

        // Sound level and ce freeze
        snd_irq = 1; idle(4, "snd_up");
        chk("snd_bit", intp & 8'h08, 8'h08);
        snd_irq = 0; ce = 0; idle(10, "snd_frz");
        chk("snd_frozen", intp & 8'h08, 8'h08);
        ce = 1; idle(4, "snd_dn");

        // Write clearing RAST_EN in the same cycle as a matching edge
        vcount = 9'h140; step("col_pre");
        hblank = 1; cs = 1; wr = 1; a1 = 1; din = 8'h00;
        step("col_edge"); cs = 0; wr = 0;
        chk("col_fire", intp & 8'h04, 8'h04);
        idle(5, "col_hold"); hblank = 0; step("col_low");
        hblank = 1; idle(3, "col_next"); hblank = 0;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            ce       = ($urandom_range(0, 3) != 0);
            cs       = ($urandom_range(0, 9) == 0);
            wr       = ($urandom_range(0, 1) == 0);
            a1       = 1'($urandom);
            din      = 8'($urandom);
            vcount   = ($urandom_range(0, 1) == 0) ? m_rl : 9'($urandom);
            if ($urandom_range(0, 3) == 0) hblank = ~hblank;
            if ($urandom_range(0, 7) == 0) vblank = ~vblank;
            dma_done = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 9) == 0) snd_irq = ~snd_irq;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m92_int_gen.md
# m92_int_gen

Interrupt source generator for the M92 main CPU. Turns video timing, sprite-DMA completion and sound-CPU requests into the eight `intp` request lines consumed by the programmable interrupt controller. It sits directly upstream of the PIC and is clocked on the same `clk`/`ce` domain. Every event is converted into a clean, stretched rising edge so the PIC's edge-triggered mode samples it reliably.

## Interface
- `HOLD`, 4: number of `ce` cycles each event pulse stays high on `intp`. Range 1–7.
- `VBL_EN_RESET`, 1: reset value of the vblank-interrupt enable.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `ce`  in  1  clock enable; all state advances only when `ce`=1
- `cs`  in  1  register select (CPU I/O decode)
- `wr`  in  1  write strobe, qualified by `cs` and `ce`
- `a1`  in  1  register address: 0 = raster line low byte, 1 = control/high byte
- `din`  in  8  write data
- `vcount`  in  9  current video line
- `hblank`  in  1  horizontal blank, level
- `vblank`  in  1  vertical blank, level
- `dma_done`  in  1  sprite DMA complete, single-`ce` pulse
- `snd_irq`  in  1  sound CPU request, asynchronous level
- `intp`  out  8  interrupt requests to the PIC: bit0 vblank, bit1 sprite DMA, bit2 raster, bit3 sound, bits 7:4 tied 0

## Operation
- Registers, written on `cs & wr & ce`:
  - `a1`=0: `RL[7:0]` ← `din`.
  - `a1`=1: `RL[8]` ← `din[0]`, `RAST_EN` ← `din[7]`, `VBL_EN` ← `din[6]`.
- Reset values: `RL`=0, `RAST_EN`=0, `VBL_EN`=`VBL_EN_RESET`, all stretch counters 0, edge and sync flops 0, `intp`=0.
- Edge detection: `hblank_q` and `vblank_q` are captured on each `ce`.
  - vblank trigger = `vblank & ~vblank_q & VBL_EN`.
  - raster trigger = `hblank & ~hblank_q & RAST_EN & (vcount == RL)`. The compare is an exact 9-bit equality; there is no wrap handling, so line values the counter never reaches never fire.
  - DMA trigger = `dma_done` sampled on `ce`.
- Stretcher, one per bits 0–2: a 3-bit counter `cnt[i]`.
  - A trigger loads `HOLD`. Otherwise the counter decrements while nonzero.
  - `intp[i]` = `cnt[i] != 0`, registered.
  - A retrigger while the counter is nonzero reloads `HOLD` and produces no new edge. Software must not expect two interrupts in that case.
- Sound (bit 3): `snd_irq` passes through a 2-flop synchronizer clocked on `clk` (not gated by `ce`). `intp[3]` = synchronized level, registered on `ce`. It is level-true and not stretched.
- Simultaneous events:
  - A register write and a raster compare in the same `ce` cycle: the compare uses the old `RL`/`RAST_EN`.
  - Clearing an enable does not cancel a pulse already in progress.
- Reset mid-pulse: `intp` goes to 0 on the next `clk` edge with `reset`=1, and all counters clear.

## Timing
- Trigger detected in `ce` cycle N: `intp[i]` rises on the clock edge that ends cycle N and stays high for exactly `HOLD` `ce` cycles.
- Latency:
  - Register write takes effect on the next `ce` cycle's compare.
  - `snd_irq` to `intp[3]`: 2 `clk` of synchronization, then up to 1 `ce` period.
- When `ce`=0, all outputs and state hold.

## Test plan
- Reset: hold `reset` 3 clocks with all inputs toggling → `intp`=0x00, `RL`=0, `RAST_EN`=0 throughout, and for one `ce` after release.
- Raster: write `a1`=0 0x40, then `a1`=1 0x81 (`RL`=0x140, `RAST_EN`=1). Drive `vcount`=0x140 with an `hblank` rising edge → `intp[2]` high for exactly 4 `ce` cycles. With `vcount`=0x040, no pulse.
- Vblank enable: `vblank` rises with `VBL_EN`=1 → `intp[0]` high for 4 `ce`. Write `a1`=1 0x00, then `vblank` rises again → no pulse.
- Retrigger: `dma_done` pulses at `ce` cycles 0 and 2 → `intp[1]` is one continuous high from cycle 1 through cycle 6 (a single edge).
- Sound level: raise `snd_irq` asynchronously → `intp[3]` high within 2 `clk` + 1 `ce`; drop it → `intp[3]` low with the same latency. `ce` held 0 for 10 clocks freezes `intp`.
- Collision: write `a1`=1 0x00 in the same `ce` cycle as a matching `hblank` edge with `RAST_EN`=1 → pulse still fires. The next matching line produces no pulse.
